stp_frame_ctrl: RTL and testbench
=================================

# stp_frame_ctrl

Frame controller placed directly after the serial-to-parallel stage that turns the FIR output stream into 16-sample frames. Detects each completed frame from `stp_valid`, snapshots the 16 parallel samples into a two-entry ping-pong frame buffer, and hands frames to the downstream block-processing engine over a valid/ready handshake. Tracks frame sequence numbers and counts frames lost to back-pressure.

## Interface
Parameters:
- `DW`, 16, sample width in bits (signed, passed through unmodified)
- `N`, 16, samples per frame
- `IDX_W`, 8, frame index width
- `DROP_W`, 8, drop counter width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `en`  in  1  capture enable; frames completing while 0 are ignored and not counted
- `stp_valid`  in  1  frame-complete level from the serial-to-parallel stage; stays high until the next input sample
- `stp_x`  in  N*DW  parallel frame; sample x_00 at [DW-1:0], x_15 at [N*DW-1:(N-1)*DW]
- `frm_valid`  out  1  frame available downstream
- `frm_ready`  in  1  downstream accepts frame
- `frm_x`  out  N*DW  frame data, same packing as `stp_x`
- `frm_idx`  out  IDX_W  sequence number of the frame on `frm_x`
- `buf_full`  out  1  both buffer entries occupied
- `drop_cnt`  out  DROP_W  frames lost to overflow, saturating

## Operation
- Capture event: `stp_valid`=1 and registered `stp_valid_d`=0 and `en`=1 at a rising edge. One capture per frame, regardless of how long `stp_valid` stays high.
- Buffer: two N*DW entries, write pointer `wp`, read pointer `rp`, occupancy state EMPTY / ONE / TWO.
- Pop event: `frm_valid`=1 and `frm_ready`=1 at a rising edge; `rp` toggles.
- Transitions: EMPTY+capture -> ONE; ONE+capture (no pop) -> TWO; ONE+pop (no capture) -> EMPTY; ONE+capture+pop -> ONE; TWO+pop (no capture) -> ONE; TWO+capture+pop -> TWO (pop frees the entry, capture accepted, no drop); TWO+capture (no pop) -> overflow.
- Overflow: frame is not stored (see Configuration); `drop_cnt` increments, holds at 2^DROP_W-1.
- Index: accepted frames tagged with a running counter stored alongside the entry; counter starts at 0, increments per accepted capture, wraps 2^IDX_W-1 -> 0. Dropped frames do not consume an index.
- `frm_valid` = state != EMPTY; `buf_full` = state == TWO; `frm_x`/`frm_idx` = entry at `rp`.
- Samples are stored bit-exact; no arithmetic on data.

## Timing
- Reset: `frm_valid`=0, `buf_full`=0, `drop_cnt`=0, `frm_idx`=0, `frm_x`=0, both entries 0, `wp`=`rp`=0, index counter 0, `stp_valid_d`=0, state EMPTY.
- Latency: capture at edge T -> `frm_valid`=1 and frame on `frm_x` after edge T (visible in cycle T+1).
- `frm_x`, `frm_idx` stable while `frm_valid`=1 and `frm_ready`=0.
- `frm_ready` may be high while `frm_valid`=0; no effect.
- `stp_x` sampled only on the capture edge; changes at other times ignored.
- `en` falling while `stp_valid` high: no capture; `en` rising later within the same `stp_valid` high period: no capture (edge already consumed).
- Reset asserted mid-operation: all state cleared immediately; buffered frames discarded.
- Back-to-back frames minimum 16 cycles apart; block also correct for captures on consecutive edges.

## Configuration
- `STP_FRAME_CTRL_OVERWRITE_EN` defined: on overflow the newest stored entry (the one not at `rp`) is overwritten with the incoming frame and the next index; the frame being presented is never disturbed; `drop_cnt` still increments (one older frame lost).
- Not defined: on overflow the incoming frame is discarded; buffer contents unchanged.

## Test plan
- Reset then one frame with `stp_x` samples 0x0001..0x0010, `frm_ready`=1 -> `frm_valid` high exactly one cycle after capture, `frm_x` matches, `frm_idx`=0, then `frm_valid`=0.
- `stp_valid` held high 20 cycles -> exactly one capture, `frm_idx` advances by one only.
- `frm_ready`=0, three frames -> `buf_full`=1 after second, `drop_cnt`=1 after third; release ready -> frames idx 0,1 (without macro) or idx 0 then idx 2 carrying third frame's data (with macro).
- State TWO with capture and pop on the same edge -> `drop_cnt` unchanged, state stays TWO, next frame idx sequential.
- 300 frames with `frm_ready`=1 -> `frm_idx` wraps 255->0; 300 overflows with `frm_ready`=0 -> `drop_cnt` saturates at 255.
- `rst` driven low while state TWO -> `frm_valid`, `buf_full`, `drop_cnt` 0 immediately, before next clock edge.

Source files
------------

// File: rtl/stp_frame_ctrl.sv
// stp_frame_ctrl
// Sits behind the serial-to-parallel stage. It takes a snapshot of each
// completed 16-sample frame into a two-entry ping-pong buffer and hands the
// frames downstream over a valid/ready handshake. Each accepted frame carries
// a sequence index. Frames lost to back-pressure are counted in a saturating
// counter.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   en         capture enable
//   stp_valid  frame-complete level from the serial-to-parallel stage
//   stp_x      parallel frame; sample 0 sits in the LSBs
//   frm_valid  a frame is presented on frm_x / frm_idx
//   frm_ready  downstream accepts the presented frame
//   frm_x      presented frame data (same packing as stp_x)
//   frm_idx    sequence number of the presented frame
//   buf_full   both buffer entries are occupied
//   drop_cnt   frames lost to overflow (saturating)
//
// Build option:
//   STP_FRAME_CTRL_OVERWRITE_EN  when defined, an overflowing frame replaces
//   the newest stored entry. Otherwise the overflowing frame is discarded.
module stp_frame_ctrl #(
  parameter int DW     = 16,
  parameter int N      = 16,
  parameter int IDX_W  = 8,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stp_valid,
  input  logic [N*DW-1:0]   stp_x,
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic [N*DW-1:0]   frm_x,
  output logic [IDX_W-1:0]  frm_idx,
  output logic              buf_full,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t              state_q, state_d;
  logic                stp_valid_prev_q, stp_valid_prev_d;
  logic                wp_q, wp_d;
  logic                rp_q, rp_d;
  logic [IDX_W-1:0]    idx_cnt_q, idx_cnt_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [N*DW-1:0]     ent_x_q   [2];
  logic [N*DW-1:0]     ent_x_d   [2];
  logic [IDX_W-1:0]    ent_idx_q [2];
  logic [IDX_W-1:0]    ent_idx_d [2];

  logic                capture;
  logic                pop;
  logic                accept;
  logic                overflow;
  logic                wr_en;
  logic                wr_sel;

  // A frame is captured once, on the rising edge of stp_valid. If en is low
  // at that edge, the frame is lost even when en rises later in the same
  // high period.
  assign capture  = stp_valid & ~stp_valid_prev_q & en;
  assign pop      = (state_q != ST_EMPTY) & frm_ready;
  // A pop on the same edge frees an entry, so a full buffer can still
  // accept a frame.
  assign accept   = capture & ((state_q != ST_TWO) | pop);
  assign overflow = capture & (state_q == ST_TWO) & ~pop;

  always_comb begin
    state_d          = state_q;
    stp_valid_prev_d = stp_valid;
    wp_d             = wp_q;
    rp_d             = rp_q;
    idx_cnt_d        = idx_cnt_q;
    drop_cnt_d       = drop_cnt_q;
    wr_en            = 1'b0;
    wr_sel           = wp_q;

    if (pop) begin
      rp_d = ~rp_q;
    end

    if (accept) begin
      wr_en     = 1'b1;
      wr_sel    = wp_q;
      wp_d      = ~wp_q;
      idx_cnt_d = idx_cnt_q + IDX_W'(1);
    end

    if (overflow) begin
      if (drop_cnt_q != {DROP_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
`ifdef STP_FRAME_CTRL_OVERWRITE_EN
      // Replace the newer entry and leave the presented frame untouched.
      // wp stays put because the entry it points to is still the older one.
      wr_en     = 1'b1;
      wr_sel    = ~rp_q;
      idx_cnt_d = idx_cnt_q + IDX_W'(1);
`endif
    end

    unique case (state_q)
      ST_EMPTY: if (accept)          state_d = ST_ONE;
      ST_ONE: begin
        if (accept && !pop)          state_d = ST_TWO;
        else if (pop && !accept)     state_d = ST_EMPTY;
      end
      ST_TWO:   if (pop && !accept)  state_d = ST_ONE;
      default:                       state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_EMPTY;
      stp_valid_prev_q <= 1'b0;
      wp_q             <= 1'b0;
      rp_q             <= 1'b0;
      idx_cnt_q        <= '0;
      drop_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      stp_valid_prev_q <= stp_valid_prev_d;
      wp_q             <= wp_d;
      rp_q             <= rp_d;
      idx_cnt_q        <= idx_cnt_d;
      drop_cnt_q       <= drop_cnt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_comb begin
        ent_x_d[gi]   = ent_x_q[gi];
        ent_idx_d[gi] = ent_idx_q[gi];
        if (wr_en && (wr_sel == 1'(gi))) begin
          ent_x_d[gi]   = stp_x;
          ent_idx_d[gi] = idx_cnt_q;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ent_x_q[gi]   <= '0;
          ent_idx_q[gi] <= '0;
        end else begin
          ent_x_q[gi]   <= ent_x_d[gi];
          ent_idx_q[gi] <= ent_idx_d[gi];
        end
      end
    end
  endgenerate

  assign frm_valid = (state_q != ST_EMPTY);
  assign buf_full  = (state_q == ST_TWO);
  assign frm_x     = ent_x_q[rp_q];
  assign frm_idx   = ent_idx_q[rp_q];
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_stp_frame_ctrl.sv
// Testbench for stp_frame_ctrl. The driver issues frames and randomized
// ready/enable patterns. A reference process models the buffer as a queue of
// frames and pushes the frames it expects to see. A monitor on the falling
// edge checks the presented outputs against the front of that queue and pops
// the queue on each handshake.
module tb_stp_frame_ctrl;

  localparam int DW = 16;
  localparam int N  = 16;
  localparam int W  = N * DW;

  logic          clk;
  logic          rst;
  logic          en;
  logic          stp_valid;
  logic [W-1:0]  stp_x;
  logic          frm_valid;
  logic          frm_ready;
  logic [W-1:0]  frm_x;
  logic [7:0]    frm_idx;
  logic          buf_full;
  logic [7:0]    drop_cnt;

  stp_frame_ctrl #(.DW(DW), .N(N), .IDX_W(8), .DROP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .stp_valid (stp_valid),
    .stp_x     (stp_x),
    .frm_valid (frm_valid),
    .frm_ready (frm_ready),
    .frm_x     (frm_x),
    .frm_idx   (frm_idx),
    .buf_full  (buf_full),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic [7:0]   idx;
  } frm_t;

  frm_t sb[$];
  int   exp_drop;
  int   exp_idx;
  int   checks;
  int   failures;
  int   pops;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rand_frame();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model. The buffer is a queue of at most two frames. The
  // monitor has already removed the frame handed over at this edge, so the
  // queue length here is the space left after that pop.
  initial begin
    logic prev_sv;
    logic cap;
    frm_t f;
    prev_sv  = 1'b0;
    exp_drop = 0;
    exp_idx  = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        sb.delete();
        exp_drop = 0;
        exp_idx  = 0;
        prev_sv  = 1'b0;
      end else begin
        cap     = stp_valid && !prev_sv && en;
        prev_sv = stp_valid;
        if (cap) begin
          f.x   = stp_x;
          f.idx = 8'(exp_idx % 256);
          if (sb.size() < 2) begin
            sb.push_back(f);
            exp_idx++;
          end else begin
            if (exp_drop < 255) exp_drop++;
`ifdef STP_FRAME_CTRL_OVERWRITE_EN
            sb[1] = f;
            exp_idx++;
`endif
          end
        end
      end
    end
  end

  // Monitor on the falling edge.
  initial begin
    frm_t f;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_valid", W'(frm_valid), W'(1'b0));
        chk("rst_full",  W'(buf_full),  W'(1'b0));
        chk("rst_drop",  W'(drop_cnt),  '0);
        chk("rst_idx",   W'(frm_idx),   '0);
        chk("rst_x",     frm_x,         '0);
      end else begin
        chk("valid", W'(frm_valid), W'(sb.size() != 0));
        chk("full",  W'(buf_full),  W'(sb.size() == 2));
        chk("drop",  W'(drop_cnt),  W'(exp_drop));
        if (frm_valid && sb.size() != 0) begin
          f = sb[0];
          chk("frm_x",   frm_x,         f.x);
          chk("frm_idx", W'(frm_idx),   W'(f.idx));
          if (frm_ready) begin
            void'(sb.pop_front());
            pops++;
            $display("pop %0d idx=%0d x=%h", pops, frm_idx, frm_x);
          end
        end
      end
    end
  end

  // Inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic frame(input int hi, input int lo, input logic [W-1:0] x);
    stp_x     = x;
    stp_valid = 1'b1;
    step();
    for (int i = 1; i < hi; i++) begin
      stp_x = rand_frame();
      step();
    end
    stp_valid = 1'b0;
    for (int i = 0; i < lo; i++) begin
      stp_x = rand_frame();
      step();
    end
  endtask

  initial begin
    logic [W-1:0] ramp;
    checks    = 0;
    failures  = 0;
    pops      = 0;
    rst       = 1'b0;
    en        = 1'b0;
    stp_valid = 1'b0;
    stp_x     = rand_frame();
    frm_ready = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    en  = 1'b1;
    step();

    // Ramp frame 1..16 with ready high.
    for (int i = 0; i < N; i++) ramp[i*DW +: DW] = 16'(i + 1);
    frm_ready = 1'b1;
    frame(1, 17, ramp);
    chk("ramp_popped", W'(pops), W'(1));

    // stp_valid held high for 20 cycles: only one capture.
    frame(20, 4, rand_frame());
    chk("hold_popped", W'(pops), W'(2));

    // Three frames with no ready: the third overflows. Then drain.
    frm_ready = 1'b0;
    for (int k = 0; k < 3; k++) frame(1, 3, rand_frame());
    chk("ovf_drop", W'(drop_cnt), W'(1));
    frm_ready = 1'b1;
    repeat (4) step();

    // Full buffer with a capture and a pop on the same edge.
    frm_ready = 1'b0;
    frame(1, 3, rand_frame());
    frame(1, 3, rand_frame());
    stp_x     = rand_frame();
    stp_valid = 1'b1;
    frm_ready = 1'b1;
    step();
    frm_ready = 1'b0;
    stp_valid = 1'b0;
    step();
    chk("cap_pop_full", W'(buf_full), W'(1'b1));
    chk("cap_pop_drop", W'(drop_cnt), W'(1));
    frm_ready = 1'b1;
    repeat (4) step();

    // Index wrap across 300 frames, then drop counter saturation.
    for (int k = 0; k < 300; k++) frame(1, 1, rand_frame());
    frm_ready = 1'b0;
    for (int k = 0; k < 302; k++) frame(1, 1, rand_frame());
    chk("drop_sat", W'(drop_cnt), W'(255));

    // Asynchronous reset while full: outputs clear before the next edge.
    rst = 1'b0;
    #1;
    chk("arst_valid", W'(frm_valid), W'(1'b0));
    chk("arst_full",  W'(buf_full),  W'(1'b0));
    chk("arst_drop",  W'(drop_cnt),  '0);
    step();
    rst = 1'b1;
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      frm_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 7) != 0);
      stp_valid = ($urandom_range(0, 2) == 0);
      stp_x     = rand_frame();
      step();
    end

    en        = 1'b0;
    stp_valid = 1'b0;
    frm_ready = 1'b1;
    repeat (5) step();
    chk("drained", W'(sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
